// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_pkg
//  Purpose  : Shared definitions for the RSA stream sequencer: core register
//             selects, operand size and sequencer state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package rsa_pkg;

  localparam int RSA_NBYTES = 32;

  localparam logic [1:0] REG_M = 2'b01;
  localparam logic [1:0] REG_E = 2'b10;
  localparam logic [1:0] REG_N = 2'b11;

  typedef enum logic [3:0] {
    ST_LOAD      = 4'd0,
    ST_WR_LAST   = 4'd1,
    ST_START     = 4'd2,
    ST_WAIT_BUSY = 4'd3,
    ST_WAIT_DONE = 4'd4,
    ST_RD_ADDR   = 4'd5,
    ST_RD_WAIT   = 4'd6,
    ST_RD_CAP    = 4'd7,
    ST_OUT       = 4'd8,
    ST_RELEASE   = 4'd9
  } rsa_state_e;

endpackage
`default_nettype wire

// File: rtl/rsa_seq_counters.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_seq_counters
//  Purpose  : Counters for the RSA stream sequencer.
//             - load byte count 0..3*NBYTES-1, held as {operand, byte k} so
//               the core reg_sel and addr (NBYTES-1-k) decode directly
//             - read index 0..NBYTES-1
//             - saturating compute-cycle counter
//  Ports    : clk, reset (async, active-high)
//             i_load_inc          advance load count (wraps after the last byte)
//             i_rd_clr/i_rd_inc   clear / advance read index
//             i_cyc_clr/i_cyc_inc clear / advance cycle counter (clear wins)
//             o_load_sel/o_load_addr   core sel/addr for the current load byte
//             o_load_first/o_load_last count is 0 / count is 3*NBYTES-1
//             o_rd_idx/o_rd_last       read index / index is NBYTES-1
//             o_cyc_count              saturating cycle count
//  Revision : 1.0  initial release
// ============================================================================
module rsa_seq_counters
  import rsa_pkg::*;
#(
  parameter int NBYTES = RSA_NBYTES,
  parameter int ADDR_W = 5,
  parameter int CYC_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load_inc,
  input  logic              i_rd_clr,
  input  logic              i_rd_inc,
  input  logic              i_cyc_clr,
  input  logic              i_cyc_inc,
  output logic [1:0]        o_load_sel,
  output logic [ADDR_W-1:0] o_load_addr,
  output logic              o_load_first,
  output logic              o_load_last,
  output logic [ADDR_W-1:0] o_rd_idx,
  output logic              o_rd_last,
  output logic [CYC_W-1:0]  o_cyc_count
);

  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NBYTES - 1);

  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_k;
  logic [ADDR_W-1:0] r_rd_idx;
  logic [CYC_W-1:0]  r_cyc;
  logic              w_k_last;

  assign w_k_last = (r_k == c_last_idx);

  // Operand select steps M -> E -> N; after the last N byte it wraps to M/0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op <= REG_M;
      r_k  <= '0;
    end else if (i_load_inc) begin
      if (w_k_last) begin
        r_k  <= '0;
        r_op <= (r_op == REG_N) ? REG_M : r_op + 2'd1;
      end else begin
        r_k <= r_k + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_idx <= '0;
    end else if (i_rd_clr) begin
      r_rd_idx <= '0;
    end else if (i_rd_inc && (r_rd_idx != c_last_idx)) begin
      r_rd_idx <= r_rd_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cyc <= '0;
    end else if (i_cyc_clr) begin
      r_cyc <= '0;
    end else if (i_cyc_inc && (r_cyc != '1)) begin
      r_cyc <= r_cyc + 1'b1;
    end
  end

  assign o_load_sel   = r_op;
  assign o_load_addr  = c_last_idx - r_k;
  assign o_load_first = (r_op == REG_M) && (r_k == '0);
  assign o_load_last  = (r_op == REG_N) && w_k_last;
  assign o_rd_idx     = r_rd_idx;
  assign o_rd_last    = (r_rd_idx == c_last_idx);
  assign o_cyc_count  = r_cyc;

endmodule
`default_nettype wire

// File: rtl/rsa_stream_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_stream_sequencer
//  Purpose  : Byte-stream front end for the 256-bit RSA core. Loads 3*NBYTES
//             operand bytes (M, E, N, each MSB-first) into the core, starts
//             it, waits for completion and streams the NBYTES result MSB-first.
//  Ports    : clk, reset (async, active-high)
//             in_data/in_valid/in_ready     operand byte stream
//             out_data/out_valid/out_ready  result byte stream
//             busy, done, cyc_count         status
//             core_we/oe/start/reg_sel/addr/wdata  to core
//             core_rdata, core_ready              from core
//             Every output is a register.
//  Revision : 1.0  initial release
// ============================================================================
module rsa_stream_sequencer
  import rsa_pkg::*;
#(
  parameter int NBYTES = RSA_NBYTES,
  parameter int ADDR_W = 5,
  parameter int CYC_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [CYC_W-1:0]  cyc_count,
  output logic              core_we,
  output logic              core_oe,
  output logic              core_start,
  output logic [1:0]        core_reg_sel,
  output logic [ADDR_W-1:0] core_addr,
  output logic [7:0]        core_wdata,
  input  logic [7:0]        core_rdata,
  input  logic              core_ready
);

  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NBYTES - 1);

  rsa_state_e        r_state, w_nxt_state;
  logic              r_in_ready, w_in_ready;
  logic [7:0]        r_out_data, w_out_data;
  logic              r_out_valid, w_out_valid;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_core_we, w_core_we;
  logic              r_core_oe, w_core_oe;
  logic              r_core_start, w_core_start;
  logic [1:0]        r_core_sel, w_core_sel;
  logic [ADDR_W-1:0] r_core_addr, w_core_addr;
  logic [7:0]        r_core_wdata, w_core_wdata;

  logic              w_accept, w_out_accept;
  logic              w_load_inc, w_rd_clr, w_rd_inc, w_cyc_clr, w_cyc_inc;
  logic [1:0]        w_load_sel;
  logic [ADDR_W-1:0] w_load_addr, w_rd_idx;
  logic              w_load_first, w_load_last, w_rd_last;

  rsa_seq_counters #(
    .NBYTES (NBYTES),
    .ADDR_W (ADDR_W),
    .CYC_W  (CYC_W)
  ) u_counters (
    .clk          (clk),
    .reset        (reset),
    .i_load_inc   (w_load_inc),
    .i_rd_clr     (w_rd_clr),
    .i_rd_inc     (w_rd_inc),
    .i_cyc_clr    (w_cyc_clr),
    .i_cyc_inc    (w_cyc_inc),
    .o_load_sel   (w_load_sel),
    .o_load_addr  (w_load_addr),
    .o_load_first (w_load_first),
    .o_load_last  (w_load_last),
    .o_rd_idx     (w_rd_idx),
    .o_rd_last    (w_rd_last),
    .o_cyc_count  (cyc_count)
  );

  assign w_accept     = (r_state == ST_LOAD) && in_valid && r_in_ready;
  assign w_out_accept = (r_state == ST_OUT) && r_out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_LOAD;
      r_in_ready   <= 1'b1;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_core_we    <= 1'b0;
      r_core_oe    <= 1'b0;
      r_core_start <= 1'b0;
      r_core_sel   <= '0;
      r_core_addr  <= '0;
      r_core_wdata <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_in_ready   <= w_in_ready;
      r_out_data   <= w_out_data;
      r_out_valid  <= w_out_valid;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_core_we    <= w_core_we;
      r_core_oe    <= w_core_oe;
      r_core_start <= w_core_start;
      r_core_sel   <= w_core_sel;
      r_core_addr  <= w_core_addr;
      r_core_wdata <= w_core_wdata;
    end
  end

  // Next-state and next-output logic; every w_* value is what the matching
  // register shows during the next state.
  always_comb begin
    w_nxt_state  = r_state;
    w_in_ready   = r_in_ready;
    w_out_data   = r_out_data;
    w_out_valid  = r_out_valid;
    w_done       = 1'b0;
    w_core_we    = 1'b0;
    w_core_oe    = r_core_oe;
    w_core_start = 1'b0;
    w_core_sel   = r_core_sel;
    w_core_addr  = r_core_addr;
    w_core_wdata = r_core_wdata;
    w_load_inc   = 1'b0;
    w_rd_clr     = 1'b0;
    w_rd_inc     = 1'b0;
    w_cyc_clr    = 1'b0;
    w_cyc_inc    = 1'b0;

    case (r_state)
      ST_LOAD: begin
        if (w_accept) begin
          w_core_we    = 1'b1;
          w_core_sel   = w_load_sel;
          w_core_addr  = w_load_addr;
          w_core_wdata = in_data;
          w_load_inc   = 1'b1;
          if (w_load_last) begin
            w_in_ready  = 1'b0;
            w_nxt_state = ST_WR_LAST;
          end
        end
      end
      ST_WR_LAST: begin
        w_core_start = 1'b1;
        w_nxt_state  = ST_START;
      end
      ST_START: begin
        w_nxt_state = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // The core drops ready one cycle after start; only then can a
        // rising ready be trusted as completion.
        if (!core_ready) begin
          w_cyc_clr   = 1'b1;
          w_nxt_state = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        w_cyc_inc = 1'b1;
        if (core_ready) begin
          w_rd_clr    = 1'b1;
          w_core_oe   = 1'b1;
          w_core_addr = c_last_idx;
          w_nxt_state = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        w_nxt_state = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        w_nxt_state = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        w_out_data  = core_rdata;
        w_out_valid = 1'b1;
        w_nxt_state = ST_OUT;
      end
      ST_OUT: begin
        if (w_out_accept) begin
          w_out_valid = 1'b0;
          if (!w_rd_last) begin
            w_rd_inc    = 1'b1;
            w_core_addr = c_last_idx - (w_rd_idx + 1'b1);
            w_nxt_state = ST_RD_ADDR;
          end else begin
            w_done      = 1'b1;
            w_core_oe   = 1'b0;
            w_nxt_state = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        w_in_ready  = 1'b1;
        w_nxt_state = ST_LOAD;
      end
      default: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
        w_core_oe   = 1'b0;
        w_nxt_state = ST_LOAD;
      end
    endcase

    // Idle means LOAD with nothing accepted yet; an accept this cycle makes
    // the count nonzero (or leaves LOAD on the final byte).
    w_busy = (w_nxt_state != ST_LOAD) || w_accept || !w_load_first;
  end

  assign in_ready     = r_in_ready;
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign core_we      = r_core_we;
  assign core_oe      = r_core_oe;
  assign core_start   = r_core_start;
  assign core_reg_sel = r_core_sel;
  assign core_addr    = r_core_addr;
  assign core_wdata   = r_core_wdata;

endmodule
`default_nettype wire
